// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: drives the four {a,b} input vectors into a gate under test,
// captures gate_o per vector after a programmable settle time, and grades the table.
//
// state  | meaning
// IDLE   | waiting for start; idx held at 0
// SETTLE | vector applied, counting down latched settle cycles
// SAMPLE | gate_o captured into scratch[idx], advance or finish
// DONE   | publish tt/pass, pulse done, bump err_cnt on mismatch
module gate_tt_sequencer #(
   parameter int SETTLE_W = 4,
   parameter int ERR_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                cont,
   input  logic [SETTLE_W-1:0] settle,
   input  logic [3:0]          expected,
   input  logic                gate_o,
   output logic                a_o,
   output logic                b_o,
   output logic                busy,
   output logic                done,
   output logic [3:0]          tt,
   output logic                pass,
   output logic [ERR_W-1:0]    err_cnt
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t              state;
   logic [1:0]          idx;
   logic [SETTLE_W-1:0] cnt;
   logic [SETTLE_W-1:0] settle_q;
   logic [3:0]          exp_q;
   logic [3:0]          scratch;

   assign a_o  = idx[1];
   assign b_o  = idx[0];
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= 2'd0;
         cnt      <= '0;
         settle_q <= '0;
         exp_q    <= 4'd0;
         scratch  <= 4'd0;
         done     <= 1'b0;
         tt       <= 4'd0;
         pass     <= 1'b0;
         err_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  settle_q <= settle;
                  exp_q    <= expected;
                  idx      <= 2'd0;
                  cnt      <= settle;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) state <= SAMPLE;
               else           cnt   <= cnt - 1'b1;
            end
            SAMPLE: begin
               scratch[idx] <= gate_o;
               if (idx == 2'd3) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 2'd1;
                  cnt   <= settle_q;
                  state <= SETTLE;
               end
            end
            DONE: begin
               tt   <= scratch;
               pass <= (scratch == exp_q);
               done <= 1'b1;
               if ((scratch != exp_q) && (err_cnt != {ERR_W{1'b1}}))
                  err_cnt <= err_cnt + 1'b1;
               idx <= 2'd0;
               // continuous mode rearms straight into SETTLE with fresh operands
               if (cont) begin
                  settle_q <= settle;
                  exp_q    <= expected;
                  cnt      <= settle;
                  state    <= SETTLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: a configurable gate model feeds gate_o, and each run is
// graded cycle by cycle against timing and table values derived from plain arithmetic.
module tb_gate_tt_sequencer;
   localparam int SW = 4;
   localparam int EW = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, cont, gate_o;
   logic [SW-1:0] settle;
   logic [3:0]    expected, gate_fn;
   logic          a_o, b_o, busy, done, pass;
   logic [3:0]    tt;
   logic [EW-1:0] err_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int err_m       = 0;

   always #5 clk = ~clk;

   // gate under test: arbitrary 2-input function, bit index {a,b}
   assign gate_o = gate_fn[{a_o, b_o}];

   gate_tt_sequencer #(.SETTLE_W(SW), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .settle(settle),
      .expected(expected), .gate_o(gate_o), .a_o(a_o), .b_o(b_o), .busy(busy),
      .done(done), .tt(tt), .pass(pass), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input int s, input logic [3:0] e, input logic [3:0] fn);
      @(negedge clk);
      settle   = SW'(s);
      expected = e;
      gate_fn  = fn;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge following the accept edge (fresh) or at the done negedge of
   // the previous continuous run (not fresh). k counts edges since the accept edge.
   task automatic check_run(input int s, input logic [3:0] e, input logic [3:0] fn,
                            input bit stay, input bit fresh, input bit scramble);
      int per, last;
      per  = s + 2;
      last = 4 * per + 1;
      for (int k = (fresh ? 0 : 1); k <= last; k++) begin
         if (k > 0) @(negedge clk);
         if (scramble && k < last - 1) begin
            start    = 1'($urandom);
            settle   = SW'($urandom);
            expected = 4'($urandom);
         end
         if (k == last - 1) begin
            start = 1'b0;
            cont  = stay;
         end
         if (k < last) begin
            chk("ab_step", 32'({a_o, b_o}), (k / per > 3) ? 3 : k / per);
            chk("done_low", 32'(done), 0);
            chk("busy_run", 32'(busy), 1);
         end else begin
            if (fn != e && err_m < 255) err_m++;
            chk("done_pulse", 32'(done), 1);
            chk("busy_end", 32'(busy), 32'(stay));
            chk("ab_end", 32'({a_o, b_o}), 0);
            chk("tt", 32'(tt), 32'(fn));
            chk("pass", 32'(pass), (fn == e) ? 1 : 0);
            chk("err_cnt", 32'(err_cnt), err_m);
         end
      end
      if (!stay) begin
         @(negedge clk);
         chk("done_single", 32'(done), 0);
         chk("busy_idle", 32'(busy), 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ab"}, 32'({a_o, b_o}), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_tt"}, 32'(tt), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"}, 32'(err_cnt), 0);
   endtask

   initial begin
      int s;
      logic [3:0] fn, e;
      rst_n = 1'b0; start = 1'b0; cont = 1'b0;
      settle = '0; expected = 4'd0; gate_fn = 4'd0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // AND gate, settle 0: done 9 edges after accept
      start_run(0, 4'b1000, 4'b1000);
      check_run(0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);
      // stuck-at-0
      start_run(0, 4'b1000, 4'b0000);
      check_run(0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1);
      // settle 3 with mid-run start/settle/expected disturbance
      start_run(3, 4'b1000, 4'b1000);
      check_run(3, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);

      for (int r = 0; r < 20; r++) begin
         s  = $urandom_range(0, 15);
         fn = 4'($urandom);
         e  = ($urandom_range(0, 1) == 1) ? fn : 4'($urandom);
         start_run(s, e, fn);
         check_run(s, e, fn, 1'b0, 1'b1, 1'b1);
      end

      // continuous mode, stuck-at-0 until err_cnt saturates
      cont = 1'b1;
      start_run(0, 4'b1000, 4'b0000);
      for (int r = 0; r < 300; r++)
         check_run(0, 4'b1000, 4'b0000, (r < 299), (r == 0), 1'b0);

      // reset during SETTLE of vector 2, then a clean run
      start_run(3, 4'b0110, 4'b0110);
      for (int k = 1; k <= 11; k++) @(negedge clk);
      chk("pre_reset_ab", 32'({a_o, b_o}), 2);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      err_m = 0;
      repeat (2) @(negedge clk);
      chk("reset_no_done", 32'(done), 0);
      rst_n = 1'b1;
      start_run(2, 4'b0110, 4'b0110);
      check_run(2, 4'b0110, 4'b0110, 1'b0, 1'b1, 1'b1);
      start_run(1, 4'b1111, 4'b0111);
      check_run(1, 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gate_tt_sequencer.md
GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE_W, 4, width of settle-cycle count input.
REQ-002 SHALL have parameter: ERR_W, 8, width of saturating failed-run counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  run request; sampled only in IDLE.
REQ-006 SHALL have port: cont  input  1  continuous mode; sampled in DONE to decide rerun.
REQ-007 SHALL have port: settle  input  SETTLE_W  extra wait cycles per vector; latched at run start.
REQ-008 SHALL have port: expected  input  4  expected truth table, bit index {a,b}; latched at run start.
REQ-009 SHALL have port: gate_o  input  1  output of the demux-built gate under test.
REQ-010 SHALL have port: a_o  output  1  gate input a, registered.
REQ-011 SHALL have port: b_o  output  1  gate input b, registered.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at run completion.
REQ-014 SHALL have port: tt  output  4  captured truth table, bit {a,b}; held until next run's DONE.
REQ-015 SHALL have port: pass  output  1  tt equals latched expected; updated in DONE only.
REQ-016 SHALL have port: err_cnt  output  ERR_W  count of failed runs, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 SHALL keep a 2-bit vector index idx; a_o = idx[1], b_o = idx[0] at all times.
REQ-019 IDLE, start=1: SHALL latch settle and expected, clear idx to 0, load wait counter with settle, go to SETTLE.
REQ-020 SETTLE: SHALL decrement wait counter each cycle; on the cycle counter equals 0, go to SAMPLE (SETTLE lasts settle+1 cycles).
REQ-021 SAMPLE: SHALL write gate_o into scratch table bit idx; if idx=3 go to DONE, else increment idx, reload counter with latched settle, go to SETTLE.
REQ-022 Per-vector time SHALL be settle+2 cycles; start-accept edge to done-high edge SHALL be 4*(settle+2)+1 cycles.
REQ-023 DONE: SHALL copy scratch table to tt, set pass = (scratch == expected), pulse done for exactly one cycle.
REQ-024 DONE, failing compare: SHALL increment err_cnt by 1, holding at 2^ERR_W-1 once reached.
REQ-025 DONE, cont=1: SHALL re-latch settle/expected, clear idx, enter SETTLE next cycle (no IDLE gap); cont=0: SHALL return to IDLE.
REQ-026 start while busy SHALL be ignored; settle/expected changes mid-run SHALL have no effect on the current run.
REQ-027 settle=0 SHALL be legal (1 SETTLE cycle, 1 SAMPLE cycle per vector).
REQ-028 idx SHALL not wrap past 3 within a run; after DONE, idx SHALL be 0 in IDLE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, idx=0, a_o=0, b_o=0, busy=0, done=0, tt=0, pass=0, err_cnt=0, counter=0.
REQ-030 Reset asserted mid-run SHALL discard partial table; no done pulse SHALL be produced for the aborted run.
REQ-031 After rst_n deasserts, first start sampled SHALL begin a normal run.

Verification
REQ-032 AND-gate DUT, expected=4'b1000, settle=0, start pulse -> done 9 cycles later, tt=4'b1000, pass=1, err_cnt=0.
REQ-033 Stuck-at-0 DUT, expected=4'b1000 -> tt=4'b0000, pass=0, err_cnt=1.
REQ-034 settle=3 -> a_o/b_o step 00,01,10,11, each held 5 cycles; done exactly 21 cycles after start accept.
REQ-035 start re-pulsed and settle changed to 7 mid-run -> ignored; run completes on original timing, single done.
REQ-036 cont=1, stuck-at-0 DUT, 300 runs -> back-to-back done pulses every 4*(settle+2)+1 cycles, err_cnt saturates at 255.
REQ-037 rst_n low during SETTLE of vector 2 -> all outputs 0 asynchronously; no done; next start yields a correct full run.
